// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM encoding,
// common command bytes and the frame parity helper.
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_BITS,
      S_ACK,
      S_RELEASE
   } state_e;

   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

   // PS/2 uses odd parity: the parity bit makes the 9-bit total odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 line plus falling-edge detect on the
// synchronized level. Flops reset to 1 (idle, released line).
module ps2_sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_fe
);

   logic r_meta, r_sync, r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
         r_prev <= 1'b1;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_fe   = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host transmitter: inhibits the clock, issues a request-to-send, shifts
// out an 8-bit command with odd parity on device clock edges and checks the ACK.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_e        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [3:0]    r_fe_cnt, w_fe_cnt_nxt;
   logic [7:0]    r_data, w_data_nxt;
   logic          r_par, w_par_nxt;
   logic          r_doe, w_doe_nxt;
   logic          w_clk_s, w_clk_fe, w_data_s, w_unused_data_fe, w_tmo;

   ps2_sync_edge u_sync_clk (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_async (ps2_clk_i),
      .o_sync  (w_clk_s),
      .o_fe    (w_clk_fe)
   );

   ps2_sync_edge u_sync_data (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_async (ps2_data_i),
      .o_sync  (w_data_s),
      .o_fe    (w_unused_data_fe)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_fe_cnt_nxt = r_fe_cnt;
      w_data_nxt   = r_data;
      w_par_nxt    = r_par;
      w_doe_nxt    = r_doe;
      tx_ready     = 1'b0;
      ps2_clk_oe   = 1'b0;
      tx_done      = 1'b0;
      tx_err       = 1'b0;
      w_tmo        = 1'b0;
      case (r_state)
         S_IDLE: begin
            tx_ready  = 1'b1;
            w_doe_nxt = 1'b0;
            if (tx_valid) begin
               w_data_nxt  = tx_data;
               w_par_nxt   = odd_parity(tx_data);
               w_cnt_nxt   = '0;
               w_state_nxt = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            ps2_clk_oe = 1'b1;
            if (r_cnt == INH_LAST) begin
               w_doe_nxt   = 1'b1;
               w_state_nxt = S_REQ;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_REQ: begin
            ps2_clk_oe   = 1'b1;
            w_cnt_nxt    = '0;
            w_fe_cnt_nxt = '0;
            w_state_nxt  = S_BITS;
         end
         S_BITS, S_ACK, S_RELEASE: begin
            w_cnt_nxt = r_cnt + 1'b1;
            // r_fe_cnt holds the number of falling edges already consumed
            if (w_clk_fe) begin
               w_cnt_nxt = '0;
               if (r_state == S_BITS) begin
                  w_fe_cnt_nxt = r_fe_cnt + 1'b1;
                  if (r_fe_cnt < 4'd8) begin
                     w_doe_nxt = ~r_data[r_fe_cnt[2:0]];
                  end else if (r_fe_cnt == 4'd8) begin
                     w_doe_nxt = ~r_par;
                  end else begin
                     w_doe_nxt   = 1'b0;
                     w_state_nxt = S_ACK;
                  end
               end else if (r_state == S_ACK) begin
                  if (w_data_s) begin
                     tx_err      = 1'b1;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_state_nxt = S_RELEASE;
                  end
               end
            end else if (r_state == S_RELEASE && w_clk_s && w_data_s) begin
               tx_done     = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_cnt == TMO_LAST) begin
               w_tmo       = 1'b1;
               tx_err      = 1'b1;
               w_doe_nxt   = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Data line drops in the timeout cycle itself rather than one cycle later.
   assign ps2_data_oe = r_doe & ~w_tmo;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_fe_cnt <= '0;
         r_data   <= '0;
         r_par    <= 1'b0;
         r_doe    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_fe_cnt <= w_fe_cnt_nxt;
         r_data   <= w_data_nxt;
         r_par    <= w_par_nxt;
         r_doe    <= w_doe_nxt;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of the
// host, with a vector table for plain sends and hand-written corner sequences.
module tb_ps2_host_tx;
   import ps2_host_tx_pkg::*;

   localparam int INH = 10000;
   localparam int TMO = 600;
   localparam int H   = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_err;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk_i, ps2_data_i;

   // open-drain wired-AND of host and device
   assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_i = dev_data & ~ps2_data_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .ps2_clk_i   (ps2_clk_i),
      .ps2_data_i  (ps2_data_i),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_done     (tx_done),
      .tx_err      (tx_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_done = 0, n_err = 0, n_both = 0, last_err_cyc = 0;
   int errors = 0, checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_done) n_done++;
      if (tx_err) begin
         n_err++;
         last_err_cyc = cyc;
      end
      if (tx_done && tx_err) n_both++;
   end

   typedef struct {
      logic [7:0]  data;
      logic        ack;
      logic [10:0] bits;   // {stop, parity, data[7:0], start} as seen on the line
      int          done;
      int          err;
   } vec_t;

   vec_t vecs[2];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
   endtask

   // Device side: measures inhibit/request, then clocks n_fe edges, sampling
   // the line just before each falling edge; ACKs on the 11th edge if asked.
   task automatic dev_frame(input int n_fe, input logic ack, output logic [10:0] bits,
                            output int inh, output int reqc, output int fall_cyc);
      int k;
      k = 0;
      bits = '1;
      inh = 0;
      reqc = 0;
      fall_cyc = 0;
      while (!ps2_clk_oe && k < 20) begin tick(1); k++; end
      while (ps2_clk_oe && !ps2_data_oe && inh < INH + 100) begin inh++; tick(1); end
      while (ps2_clk_oe && ps2_data_oe && reqc < 10) begin reqc++; tick(1); end
      for (int n = 0; n < n_fe; n++) begin
         tick(H / 2);
         bits[n] = ps2_data_i;
         if (n == 10 && ack) dev_data = 1'b0;
         tick(H / 2);
         dev_clk  = 1'b0;
         fall_cyc = cyc;
         tick(H);
         dev_clk = 1'b1;
      end
      tick(4);
      dev_data = 1'b1;
   endtask

   task automatic wait_end(input int d0, input int e0, input int budget);
      int k;
      k = 0;
      while (n_done == d0 && n_err == e0 && k < budget) begin tick(1); k++; end
      if (k >= budget) chk("end_of_frame_timeout", k, 0);
   endtask

   initial begin
      logic [10:0] bits;
      int inh, reqc, fcyc, d0, e0, k, rdy;

      vecs[0] = '{8'h01,          1'b1, 11'h402, 1, 0};
      vecs[1] = '{PS2_CMD_ENABLE, 1'b0, 11'h5E8, 0, 1};

      tick(3);
      chk("rst_ready", tx_ready, 1);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      chk("rst_pulses", tx_done | tx_err, 0);
      rst = 1'b1;
      tick(3);
      chk("idle_ready", tx_ready, 1);
      chk("idle_oe", {ps2_clk_oe, ps2_data_oe}, 0);

      // set-LEDs with tx_valid held; data changed mid-frame becomes the next frame
      d0 = n_done; e0 = n_err;
      tx_data  = PS2_CMD_SET_LEDS;
      tx_valid = 1'b1;
      tick(1);
      tx_data = 8'h00;
      dev_frame(11, 1'b1, bits, inh, reqc, fcyc);
      chk("ed_inhibit", inh, INH);
      chk("ed_req", reqc, 1);
      chk("ed_bits", bits, 11'h7DA);
      k = 0;
      while (!tx_ready && k < 400) begin tick(1); k++; end
      rdy = 0;
      while (tx_ready && rdy < 5) begin rdy++; tick(1); end
      tx_valid = 1'b0;
      chk("ed_done", n_done - d0, 1);
      chk("ed_err", n_err - e0, 0);
      chk("b2b_ready_cycles", rdy, 1);
      chk("b2b_clk_oe", ps2_clk_oe, 1);
      d0 = n_done; e0 = n_err;
      dev_frame(11, 1'b1, bits, inh, reqc, fcyc);
      chk("h00_inhibit", inh, INH);
      chk("h00_bits", bits, 11'h600);
      wait_end(d0, e0, 400);
      chk("h00_done", n_done - d0, 1);
      chk("h00_err", n_err - e0, 0);
      tick(20);
      chk("no_third_frame", ps2_clk_oe, 0);
      chk("no_third_ready", tx_ready, 1);

      for (int i = 0; i < 2; i++) begin
         d0 = n_done; e0 = n_err;
         send(vecs[i].data);
         dev_frame(11, vecs[i].ack, bits, inh, reqc, fcyc);
         wait_end(d0, e0, 400);
         tick(2);
         chk($sformatf("v%0d_inhibit", i), inh, INH);
         chk($sformatf("v%0d_req", i), reqc, 1);
         chk($sformatf("v%0d_bits", i), bits, vecs[i].bits);
         chk($sformatf("v%0d_done", i), n_done - d0, vecs[i].done);
         chk($sformatf("v%0d_err", i), n_err - e0, vecs[i].err);
         chk($sformatf("v%0d_ready", i), tx_ready, 1);
         chk($sformatf("v%0d_oe", i), {ps2_clk_oe, ps2_data_oe}, 0);
      end

      // device stalls after 5 edges; the edge is seen two flops after the line drops
      d0 = n_done; e0 = n_err;
      send(PS2_CMD_RESET);
      dev_frame(5, 1'b1, bits, inh, reqc, fcyc);
      chk("tmo_bits", bits[4:0], 5'b11110);
      wait_end(d0, e0, TMO + 100);
      chk("tmo_err", n_err - e0, 1);
      chk("tmo_done", n_done - d0, 0);
      chk("tmo_latency", last_err_cyc - fcyc, TMO + 2);
      chk("tmo_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      tick(1);
      chk("tmo_ready", tx_ready, 1);

      // reset in the middle of the data bits
      d0 = n_done; e0 = n_err;
      send(PS2_RSP_ACK);
      dev_frame(3, 1'b1, bits, inh, reqc, fcyc);
      chk("mid_bits", bits[2:0], 3'b100);
      chk("mid_data_oe", ps2_data_oe, 1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      tick(2);
      rst = 1'b1;
      tick(5);
      chk("mid_rst_ready", tx_ready, 1);
      chk("mid_rst_oe_after", {ps2_clk_oe, ps2_data_oe}, 0);
      chk("mid_rst_pulses", (n_done - d0) + (n_err - e0), 0);

      chk("never_both", n_both, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, clock-low inhibit time in clk cycles (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, maximum clk cycles between device clock falling edges (20 ms at 100 MHz).
REQ-003 clk  in  1  system clock; the block's only clock.
REQ-004 rst  in  1  reset; asynchronous, active-low.
REQ-005 tx_valid  in  1  command byte offered.
REQ-006 tx_data  in  8  command byte (e.g. 8'hED set-LEDs).
REQ-007 tx_ready  out  1  high in IDLE only; a byte is accepted when tx_valid and tx_ready are both high.
REQ-008 ps2_clk_i  in  1  PS/2 clock line level, asynchronous.
REQ-009 ps2_data_i  in  1  PS/2 data line level, asynchronous.
REQ-010 ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release (open-drain).
REQ-011 ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release.
REQ-012 tx_done  out  1  one-cycle pulse: frame sent and device ACK received.
REQ-013 tx_err  out  1  one-cycle pulse: missing ACK or timeout.

Function
REQ-014 ps2_clk_i and ps2_data_i SHALL each pass through a 2-flop synchronizer; a device falling edge (fe) is synced clock 1 in the previous cycle and 0 in the current one.
REQ-015 States SHALL be IDLE, INHIBIT, REQ, BITS, ACK, RELEASE.
REQ-016 IDLE: both oe outputs 0; on acceptance, latch tx_data, compute odd parity (~^tx_data), go to INHIBIT.
REQ-017 INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-018 REQ: clk_oe=1, data_oe=1 (start bit) for one cycle, then BITS with clk_oe=0 and data_oe held at 1.
REQ-019 BITS: on fe number n (n=1..8), data_oe SHALL become ~data[n-1] (LSB first); on fe 9, ~parity; on fe 10, 0 (stop bit, line released); then ACK.
REQ-020 ACK: on fe 11, synced data 0 means ACK and the state goes to RELEASE; synced data 1 SHALL pulse tx_err and return to IDLE.
REQ-021 RELEASE: wait until synced clock and data are both 1, then pulse tx_done and go to IDLE.
REQ-022 Timeout counter SHALL clear on entry to BITS and on every fe; in BITS, ACK or RELEASE, reaching TIMEOUT_CYCLES SHALL release both lines, pulse tx_err and return to IDLE.
REQ-023 fe SHALL be ignored in IDLE, INHIBIT and REQ.
REQ-024 tx_valid while not ready SHALL be ignored; tx_data is not re-sampled mid-frame.
REQ-025 tx_done and tx_err SHALL never assert in the same cycle.

Reset
REQ-026 On rst low: state IDLE, oe outputs 0, tx_done/tx_err 0, counters 0, synchronizer flops 1.
REQ-027 rst asserted mid-frame SHALL immediately release both lines; the byte is discarded with no tx_done/tx_err.

Structure
REQ-028 Shared package: state encoding and PS/2 command constants (8'hED, 8'hFF, 8'hF4, ACK byte 8'hFA).
REQ-029 One sub-module, ps2_sync_edge (2-flop sync plus falling-edge detect), instantiated for the clock and data lines.

Verification
REQ-030 Send 8'hED with a device model ACKing: clk_oe low for 10000 cycles, start bit 0, data bits 1,0,1,1,0,1,1,1, parity 1, stop released -> one tx_done.
REQ-031 Send 8'h00: parity bit SHALL be 1; send 8'h01: parity bit SHALL be 0.
REQ-032 Device leaves data high at the 11th fe -> one tx_err pulse, no tx_done, back to IDLE.
REQ-033 Device stops clocking after 5 fe -> tx_err exactly TIMEOUT_CYCLES after the 5th fe, both oe outputs 0.
REQ-034 rst pulsed during BITS -> both oe outputs 0 at once, tx_ready=1 after release, no pulses.
REQ-035 tx_valid held high through a frame -> exactly one frame sent; the next frame starts on the first cycle tx_ready returns high.
